// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Redirect, instruction-memory and decode handshake bundle
//                for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;

   modport master (
      input  redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, if_ready,
      output imem_req, imem_addr, if_valid, if_pc, if_instr
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, if_ready,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : In-order instruction fetch with a PC-tagged fetch buffer and
//                redirect flush that discards responses still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire logic     clk,
   input  wire logic     n_rst,
   instr_fetch_if.master bus
);
   localparam int unsigned     c_CW   = $clog2(DEPTH + 1);
   localparam int unsigned     c_PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Back-to-back redirects can owe more than DEPTH responses, so discard gets headroom.
   localparam int unsigned     c_DW   = c_CW + 4;
   localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_pc    [DEPTH];
   logic [31:0]      r_instr [DEPTH];
   logic [DEPTH-1:0] r_filled;
   logic [c_PW-1:0]  r_head;
   logic [c_PW-1:0]  r_tail;
   logic [c_PW-1:0]  r_fill;
   logic [c_CW-1:0]  r_count;
   logic [c_CW-1:0]  r_pending;
   logic [c_DW-1:0]  r_discard;

   logic             w_alloc;
   logic             w_deq;
   logic             w_drop;
   logic             w_fill;
   logic [c_DW-1:0]  w_owed;
   logic             w_unused;

   function automatic logic [c_PW-1:0] inc_ptr(input logic [c_PW-1:0] p);
      return (p == c_LAST) ? '0 : p + 1'b1;
   endfunction

   assign bus.imem_req  = n_rst & (r_count < c_CW'(DEPTH)) & ~bus.redirect_valid;
   assign bus.imem_addr = r_fetch_pc;
   assign bus.if_valid  = r_filled[r_head] & ~bus.redirect_valid;
   assign bus.if_pc     = r_pc[r_head];
   assign bus.if_instr  = r_instr[r_head];

   assign w_alloc  = bus.imem_req & bus.imem_ready;
   assign w_deq    = bus.if_valid & bus.if_ready;
   assign w_drop   = bus.imem_rvalid & (r_discard != '0);
   assign w_fill   = bus.imem_rvalid & (r_discard == '0) & (r_pending != '0) & ~bus.redirect_valid;
   // A response arriving in the redirect cycle is itself dropped, so it is not owed.
   assign w_owed   = r_discard + c_DW'(r_pending) - c_DW'(bus.imem_rvalid);
   assign w_unused = ^bus.redirect_pc[1:0];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_fetch_pc <= RESET_PC;
         r_filled   <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_fill     <= '0;
         r_count    <= '0;
         r_pending  <= '0;
         r_discard  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_pc[i]    <= '0;
            r_instr[i] <= '0;
         end
      end else if (bus.redirect_valid) begin
         r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
         r_filled   <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_fill     <= '0;
         r_count    <= '0;
         r_pending  <= '0;
         r_discard  <= w_owed;
      end else begin
         if (w_alloc) begin
            r_pc[r_tail]     <= r_fetch_pc;
            r_filled[r_tail] <= 1'b0;
            r_tail           <= inc_ptr(r_tail);
            r_fetch_pc       <= r_fetch_pc + 32'd4;
         end
         if (w_fill) begin
            r_instr[r_fill]  <= bus.imem_rdata;
            r_filled[r_fill] <= 1'b1;
            r_fill           <= inc_ptr(r_fill);
         end
         if (w_drop) begin
            r_discard <= r_discard - c_DW'(1);
         end
         if (w_deq) begin
            r_filled[r_head] <= 1'b0;
            r_head           <= inc_ptr(r_head);
         end
         r_count   <= r_count + c_CW'(w_alloc) - c_CW'(w_deq);
         r_pending <= r_pending + c_CW'(w_alloc) - c_CW'(w_fill);
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (n_rst) begin
         assert (!(bus.imem_rvalid && (r_discard == '0) && (r_pending == '0)))
            else $error("instr_fetch: imem_rvalid with no outstanding request");
      end
   end
`endif
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed bench for instr_fetch with a queue-based memory and
//                fetch-buffer scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          filled;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      bit          live;
   } req_t;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   instr_fetch_if bus ();

   instr_fetch #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   ent_t        m_buf[$];
   req_t        mem_q[$];
   logic [31:0] m_pc;
   logic [31:0] acc_log[$];
   logic [31:0] xfer_log[$];
   bit          mem_en;
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_fail = 0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_log(input string tag, input logic [31:0] q[$], input int idx,
                          input logic [31:0] exp);
      logic [31:0] obs;
      obs = (idx < q.size()) ? q[idx] : 32'hxxxx_xxxx;
      chk(tag, obs, exp);
   endtask

   // One clock: drive memory, compare outputs, then advance the model at the edge.
   task automatic cyc();
      req_t item;
      bit   exp_req, exp_v, acc, deq, rv;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (mem_en && mem_q.size() > 0) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mem_fn(mem_q[0].addr);
      end
      #1;
      exp_req = n_rst && (m_buf.size() < DEPTH) && !bus.redirect_valid;
      exp_v   = n_rst && (m_buf.size() > 0) && m_buf[0].filled && !bus.redirect_valid;
      chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
      chk("if_valid", 32'(bus.if_valid), 32'(exp_v));
      if (exp_v) begin
         chk("if_pc", bus.if_pc, m_buf[0].pc);
         chk("if_instr", bus.if_instr, m_buf[0].instr);
      end
      acc = exp_req && bus.imem_ready;
      deq = exp_v && bus.if_ready;
      rv  = bus.imem_rvalid;
      if (acc) acc_log.push_back(m_pc);
      if (deq) xfer_log.push_back(m_buf[0].pc);
      @(posedge clk);
      if (n_rst) begin
         if (rv) item = mem_q.pop_front();
         if (bus.redirect_valid) begin
            m_buf.delete();
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            m_pc = {bus.redirect_pc[31:2], 2'b00};
         end else begin
            if (deq) m_buf.delete(0);
            if (rv && item.live) begin
               for (int i = 0; i < m_buf.size(); i++) begin
                  if (!m_buf[i].filled) begin
                     m_buf[i].filled = 1'b1;
                     m_buf[i].instr  = mem_fn(item.addr);
                     break;
                  end
               end
            end
            if (acc) begin
               m_buf.push_back('{m_pc, 32'h0, 1'b0});
               mem_q.push_back('{m_pc, 1'b1});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_buf.delete();
      mem_q.delete();
      m_pc = RESET_PC;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      bus.redirect_valid = 1'b0;
      model_reset();
      cyc();
      cyc();
      n_rst = 1'b1;
   endtask

   task automatic clear_logs();
      acc_log.delete();
      xfer_log.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int          first;
      int          n;
      int          nb;
      bit          all_filled;
      logic [31:0] hold;

      n_rst              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_ready     = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.if_ready       = 1'b0;
      mem_en             = 1'b0;
      model_reset();

      // Reset values
      @(negedge clk);
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_imem_addr", bus.imem_addr, RESET_PC);
      chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_if_pc", bus.if_pc, 32'd0);
      chk("rst_if_instr", bus.if_instr, 32'd0);
      cyc();

      // Streaming fetch
      n_rst          = 1'b1;
      bus.imem_ready = 1'b1;
      bus.if_ready   = 1'b1;
      mem_en         = 1'b1;
      clear_logs();
      first = -1;
      for (int c = 0; c < 10; c++) begin
         nb = xfer_log.size();
         cyc();
         if (xfer_log.size() > nb && first < 0) first = c;
      end
      chk("t1_first_req", acc_log.size() > 0 ? acc_log[0] : 32'hxxxx_xxxx, RESET_PC);
      chk("t1_first_xfer_cycle", 32'(first), 32'd2);
      chk_log("t1_pc0", xfer_log, 0, 32'h0);
      chk_log("t1_pc1", xfer_log, 1, 32'h4);
      chk_log("t1_pc2", xfer_log, 2, 32'h8);
      chk_log("t1_pc3", xfer_log, 3, 32'hC);

      // Decode stalled: buffer fills, requests stop, then drain
      do_reset();
      bus.if_ready = 1'b0;
      clear_logs();
      repeat (6) cyc();
      chk("t2_req_count", 32'(acc_log.size()), 32'd2);
      chk_log("t2_req0", acc_log, 0, 32'h0);
      chk_log("t2_req1", acc_log, 1, 32'h4);
      chk("t2_req_idle", 32'(bus.imem_req), 32'd0);
      bus.if_ready = 1'b1;
      clear_logs();
      repeat (6) cyc();
      chk_log("t2_drain0", xfer_log, 0, 32'h0);
      chk_log("t2_drain1", xfer_log, 1, 32'h4);
      chk_log("t2_resume", acc_log, 0, 32'h8);

      // Memory not ready for 3 cycles
      bus.imem_ready = 1'b0;
      repeat (3) cyc();
      hold = m_pc;
      clear_logs();
      for (int c = 0; c < 3; c++) begin
         chk("t3_addr_hold", bus.imem_addr, hold);
         cyc();
      end
      chk("t3_no_alloc", 32'(acc_log.size()), 32'd0);
      bus.imem_ready = 1'b1;
      cyc();
      chk_log("t3_resume", acc_log, 0, hold);

      // Redirect with two requests in flight
      bus.imem_ready = 1'b0;
      repeat (3) cyc();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h10;
      cyc();
      bus.redirect_valid = 1'b0;
      mem_en         = 1'b0;
      bus.if_ready   = 1'b0;
      bus.imem_ready = 1'b1;
      clear_logs();
      repeat (3) cyc();
      chk("t4_inflight", 32'(acc_log.size()), 32'd2);
      chk_log("t4_req0", acc_log, 0, 32'h10);
      chk_log("t4_req1", acc_log, 1, 32'h14);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h103;
      cyc();
      bus.redirect_valid = 1'b0;
      clear_logs();
      mem_en       = 1'b1;
      bus.if_ready = 1'b1;
      repeat (9) cyc();
      chk_log("t4_new_req", acc_log, 0, 32'h100);
      chk_log("t4_first_pc", xfer_log, 0, 32'h100);
      chk_log("t4_second_pc", xfer_log, 1, 32'h104);

      // Redirect coinciding with a response and a transfer
      n = 0;
      while (!(m_buf.size() > 0 && m_buf[0].filled && mem_q.size() > 0 && mem_q[0].live)
             && n < 20) begin
         cyc();
         n++;
      end
      chk("t5_setup_found", 32'(n < 20), 32'd1);
      clear_logs();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      cyc();
      bus.redirect_valid = 1'b0;
      chk("t5_no_xfer", 32'(xfer_log.size()), 32'd0);
      repeat (8) cyc();
      chk_log("t5_first_pc", xfer_log, 0, 32'h200);
      chk_log("t5_second_pc", xfer_log, 1, 32'h204);

      // Asynchronous reset with a full buffer
      bus.if_ready = 1'b0;
      n = 0;
      all_filled = 1'b0;
      while (!all_filled && n < 20) begin
         cyc();
         n++;
         all_filled = (m_buf.size() == DEPTH);
         foreach (m_buf[i]) all_filled &= m_buf[i].filled;
      end
      chk("t6_setup_full", 32'(all_filled), 32'd1);
      chk("t6_valid_before", 32'(bus.if_valid), 32'd1);
      n_rst = 1'b0;
      model_reset();
      #1;
      chk("t6_async_if_valid", 32'(bus.if_valid), 32'd0);
      chk("t6_async_imem_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
      cyc();
      n_rst        = 1'b1;
      bus.if_ready = 1'b1;
      clear_logs();
      repeat (6) cyc();
      chk_log("t6_first_req", acc_log, 0, RESET_PC);
      chk_log("t6_first_pc", xfer_log, 0, RESET_PC);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
